// File: rtl/pk_arb_pkg.sv
// Shared definitions for the peak-detect event arbiter: register map,
// field positions, the queued event record and the POP word formatter.
package pk_arb_pkg;

    // Avalon word addresses
    localparam logic [1:0] ADDR_STATUS  = 2'd0;
    localparam logic [1:0] ADDR_POP     = 2'd1;
    localparam logic [1:0] ADDR_CTRL    = 2'd2;
    localparam logic [1:0] ADDR_EVCOUNT = 2'd3;

    // Field positions inside the 32-bit register words
    localparam int POP_VALID_BIT    = 31;
    localparam int POP_SRC_LSB      = 28;
    localparam int CTRL_IRQEN_BIT   = 16;
    localparam int STATUS_CNT_LSB   = 8;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_EMPTY_BIT = 0;

    // Widest payload the register map can carry below the source field
    localparam int MAX_DW = 24;
    localparam int SRC_W  = 3;

    typedef struct packed {
        logic [SRC_W-1:0]  src;
        logic [MAX_DW-1:0] data;
    } event_t;

    // Format a queued event as the word returned by a successful POP read.
    function automatic logic [31:0] pop_word(input event_t ev);
        logic [31:0] w;
        w = 32'd0;
        w[POP_VALID_BIT]            = 1'b1;
        w[POP_SRC_LSB +: SRC_W]     = ev.src;
        w[MAX_DW-1:0]               = ev.data;
        return w;
    endfunction

    // Index of the lowest set bit of v (0 when v is all zero).
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/pk_event_fifo.sv
// Synchronous event FIFO. A pop on an empty FIFO is ignored; a push on a full
// FIFO is accepted only when a pop frees a slot in the same cycle.
module pk_event_fifo #(
    parameter int W     = 19,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);
    localparam logic [AW:0] ZERO_CNT = (AW+1)'(0);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] wr_ptr_d;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          do_push_s;
    logic          do_pop_s;

    assign do_pop_s  = pop & (count_q != ZERO_CNT);
    assign do_push_s = push & ((count_q != FULL_CNT) | do_pop_s);

    // Next pointer and occupancy values from the accepted push/pop pair.
    always_comb begin
        wr_ptr_d = do_push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = do_pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase
    end

    // Payload storage; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointer and occupancy registers; reset flushes the queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= ZERO_CNT;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == ZERO_CNT);
    assign count = count_q;

endmodule

// File: rtl/pk_event_arbiter.sv
// Round-robin collector of detector events into a FIFO read by the Nios over
// a 4-word Avalon-MM slave (STATUS, POP, CTRL, EVCOUNT) with a level irq.
module pk_event_arbiter
    import pk_arb_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int DW    = 16,
    parameter int DEPTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_SRC-1:0]    req,
    input  logic [N_SRC*DW-1:0] req_data,
    output logic [N_SRC-1:0]    ack,
    input  logic [1:0]          address,
    input  logic                read,
    input  logic                write,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic                irq
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = SRC_W + DW;

    // Registered state
    logic [N_SRC-1:0] ack_q;
    logic [N_SRC-1:0] ack_d;
    logic [2:0]       last_q;
    logic [2:0]       last_d;
    logic [N_SRC-1:0] mask_q;
    logic [N_SRC-1:0] mask_d;
    logic             irq_en_q;
    logic             irq_en_d;
    logic [31:0]      evcount_q;
    logic [31:0]      evcount_d;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic             irq_q;
    logic             irq_d;

    // Combinational signals
    logic [N_SRC-1:0] eligible_s;
    logic [N_SRC-1:0] upper_s;
    logic [7:0]       pick_s;
    logic             can_push_s;
    logic             grant_valid_s;
    logic [2:0]       grant_idx_s;
    logic             pop_s;
    logic             wr_ctrl_s;
    logic             wr_evcount_s;
    logic [FW-1:0]    fifo_wdata_s;
    logic [FW-1:0]    fifo_rdata_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CW-1:0]    fifo_count_s;
    event_t           head_ev_s;
    logic [31:0]      rd_mux_s;
    logic             unused_s;

    assign pop_s        = read  & (address == ADDR_POP) & ~fifo_empty_s;
    assign wr_ctrl_s    = write & (address == ADDR_CTRL);
    assign wr_evcount_s = write & (address == ADDR_EVCOUNT);
    assign can_push_s   = ~fifo_full_s | pop_s;
    assign eligible_s   = req & mask_q & ~ack_q;

    // Round robin: prefer eligible sources above the last grant, else wrap to the lowest.
    always_comb begin
        upper_s = '0;
        for (int i = 0; i < N_SRC; i++) begin
            upper_s[i] = eligible_s[i] & (3'(i) > last_q);
        end
        pick_s        = (|upper_s) ? 8'(upper_s) : 8'(eligible_s);
        grant_idx_s   = lowest_set(pick_s);
        grant_valid_s = (|eligible_s) & can_push_s;
        fifo_wdata_s  = {grant_idx_s, req_data[grant_idx_s*DW +: DW]};
    end

    // Next-state for grant pulse, round-robin pointer, control and event counter.
    always_comb begin
        ack_d = '0;
        for (int i = 0; i < N_SRC; i++) begin
            ack_d[i] = grant_valid_s & (grant_idx_s == 3'(i));
        end
        last_d   = grant_valid_s ? grant_idx_s : last_q;
        mask_d   = wr_ctrl_s ? writedata[N_SRC-1:0] : mask_q;
        irq_en_d = wr_ctrl_s ? writedata[CTRL_IRQEN_BIT] : irq_en_q;
        if (wr_evcount_s) begin
            evcount_d = 32'd0;
        end else begin
            evcount_d = evcount_q + {31'd0, grant_valid_s};
        end
        irq_d = irq_en_q & ~fifo_empty_s;
    end

    // Head of the queue viewed as an event record.
    always_comb begin
        head_ev_s      = '0;
        head_ev_s.src  = fifo_rdata_s[FW-1:DW];
        head_ev_s.data = MAX_DW'(fifo_rdata_s[DW-1:0]);
    end

    // Read data selection; a POP on an empty queue returns zero.
    always_comb begin
        rd_mux_s = 32'd0;
        case (address)
            ADDR_STATUS: begin
                rd_mux_s[STATUS_CNT_LSB +: 8]  = 8'(fifo_count_s);
                rd_mux_s[STATUS_FULL_BIT]      = fifo_full_s;
                rd_mux_s[STATUS_EMPTY_BIT]     = fifo_empty_s;
            end
            ADDR_POP: begin
                rd_mux_s = fifo_empty_s ? 32'd0 : pop_word(head_ev_s);
            end
            ADDR_CTRL: begin
                rd_mux_s[N_SRC-1:0]      = mask_q;
                rd_mux_s[CTRL_IRQEN_BIT] = irq_en_q;
            end
            ADDR_EVCOUNT: begin
                rd_mux_s = evcount_q;
            end
            default: begin
                rd_mux_s = 32'd0;
            end
        endcase
        readdata_d = read ? rd_mux_s : readdata_q;
    end

    // Arbiter state: grant pulse and last granted source.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_q  <= '0;
            last_q <= 3'(N_SRC - 1);
        end else begin
            ack_q  <= ack_d;
            last_q <= last_d;
        end
    end

    // Control register and granted-event counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q    <= '0;
            irq_en_q  <= 1'b0;
            evcount_q <= 32'd0;
        end else begin
            mask_q    <= mask_d;
            irq_en_q  <= irq_en_d;
            evcount_q <= evcount_d;
        end
    end

    // Registered bus read data and interrupt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata_q <= 32'd0;
            irq_q      <= 1'b0;
        end else begin
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    pk_event_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (grant_valid_s),
        .pop   (pop_s),
        .wdata (fifo_wdata_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Control bits beyond the enable mask and irq_en are reserved.
    assign unused_s = ^writedata;

    assign ack      = ack_q;
    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_pk_event_arbiter.sv
// Scoreboard bench for pk_event_arbiter: a queue-based reference model
// predicts acks, read data and irq; a monitor pops and compares.
module tb_pk_event_arbiter;
    localparam int N     = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    ack;
    logic [1:0]      address;
    logic            read;
    logic            write;
    logic [31:0]     writedata;
    logic [31:0]     readdata;
    logic            irq;

    always #5 clk = ~clk;

    pk_event_arbiter #(.N_SRC(N), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
        .address(address), .read(read), .write(write), .writedata(writedata),
        .readdata(readdata), .irq(irq)
    );

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    int   cur_cyc  = 0;
    exp_t ack_exp[$];
    exp_t rd_exp[$];
    exp_t irq_exp[$];
    logic [31:0] ack_seen[$];

    // Requesters
    bit          pend [N];
    logic [DW-1:0] pdata [N];
    bit          regen_always [N];
    int          regen_pct = 0;

    // Reference model state
    logic [31:0] m_fifo[$];
    logic [N-1:0] m_mask;
    bit          m_irqen;
    logic [31:0] m_ev;
    int          m_last;
    int          m_prev_grant;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cur_cyc);
        end
    endtask

    task automatic m_reset();
        m_fifo.delete();
        m_mask       = '0;
        m_irqen      = 1'b0;
        m_ev         = 32'd0;
        m_last       = N - 1;
        m_prev_grant = -1;
        ack_exp.delete();
        rd_exp.delete();
        irq_exp.delete();
    endtask

    // One clock cycle: update requesters, drive the bus, predict the outcome.
    task automatic step(input bit rst, input bit rd, input bit wr,
                        input logic [1:0] addr, input logic [31:0] wd);
        int          n;
        int          g;
        int          s;
        bit          pop;
        logic [31:0] rv;
        if (m_prev_grant >= 0) pend[m_prev_grant] = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && (regen_always[i] || ($urandom_range(99) < regen_pct))) begin
                pend[i]  = 1'b1;
                pdata[i] = DW'($urandom);
            end
        end
        for (int i = 0; i < N; i++) begin
            req[i] = pend[i];
            req_data[i*DW +: DW] = pdata[i];
        end
        reset = rst; read = rd; write = wr; address = addr; writedata = wd;
        if (rst) begin
            m_reset();
        end else begin
            n   = m_fifo.size();
            pop = rd && (addr == 2'd1) && (n > 0);
            g   = -1;
            if (n < DEPTH || pop) begin
                for (int k = 1; k <= N; k++) begin
                    s = (m_last + k) % N;
                    if (pend[s] && m_mask[s] && s != m_prev_grant) begin
                        g = s;
                        break;
                    end
                end
            end
            case (addr)
                2'd0:    rv = (32'(n) << 8) | ((n == DEPTH) ? 32'd2 : 32'd0) | ((n == 0) ? 32'd1 : 32'd0);
                2'd1:    rv = pop ? m_fifo[0] : 32'd0;
                2'd2:    rv = 32'(m_mask) | (m_irqen ? 32'h0001_0000 : 32'd0);
                default: rv = m_ev;
            endcase
            irq_exp.push_back('{cur_cyc + 1, (m_irqen && n > 0) ? 32'd1 : 32'd0});
            if (rd) rd_exp.push_back('{cur_cyc + 1, rv});
            if (g >= 0) ack_exp.push_back('{cur_cyc + 1, 32'd1 << g});
            if (pop) void'(m_fifo.pop_front());
            if (g >= 0) begin
                m_fifo.push_back(32'h8000_0000 | (32'(g) << 28) | 32'(pdata[g]));
                m_last = g;
            end
            if (wr && addr == 2'd3) m_ev = 32'd0;
            else if (g >= 0)        m_ev = m_ev + 32'd1;
            if (wr && addr == 2'd2) begin
                m_mask  = wd[N-1:0];
                m_irqen = wd[16];
            end
            m_prev_grant = g;
        end
        cur_cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask
    task automatic rd_reg(input logic [1:0] a);
        step(1'b0, 1'b1, 1'b0, a, 32'd0);
    endtask
    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        step(1'b0, 1'b0, 1'b1, a, d);
    endtask
    task automatic raise(input int i, input logic [DW-1:0] d);
        pend[i]  = 1'b1;
        pdata[i] = d;
    endtask

    // Monitor: compare outputs a moment after each rising edge.
    exp_t mon_e;
    always begin
        @(posedge clk);
        #1;
        if (reset) begin
            check("reset_ack", 32'(ack), 32'd0);
            check("reset_irq", 32'(irq), 32'd0);
            check("reset_readdata", readdata, 32'd0);
        end else begin
            while (ack_exp.size() > 0 && ack_exp[0].cyc < cur_cyc) begin
                mon_e = ack_exp.pop_front();
                check("ack_missed", 32'(ack), mon_e.val);
            end
            if (ack_exp.size() > 0 && ack_exp[0].cyc == cur_cyc) begin
                mon_e = ack_exp.pop_front();
                check("ack", 32'(ack), mon_e.val);
            end else begin
                check("ack_idle", 32'(ack), 32'd0);
            end
            if (ack != '0) ack_seen.push_back(32'(ack));
            if (irq_exp.size() > 0) begin
                mon_e = irq_exp.pop_front();
                check("irq", 32'(irq), mon_e.val);
            end
            if (rd_exp.size() > 0 && rd_exp[0].cyc == cur_cyc) begin
                mon_e = rd_exp.pop_front();
                check("readdata", readdata, mon_e.val);
            end
        end
    end

    initial begin
        reset = 1'b1; req = '0; req_data = '0; read = 1'b0; write = 1'b0;
        address = 2'd0; writedata = 32'd0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; pdata[i] = '0; regen_always[i] = 1'b0;
        end
        m_reset();
        @(negedge clk);

        // Reset state
        repeat (3) step(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
        rd_reg(2'd0);
        check("tp_status_reset", readdata, 32'h0000_0001);
        rd_reg(2'd1);
        check("tp_pop_empty", readdata, 32'h0000_0000);
        check("tp_irq_reset", 32'(irq), 32'd0);

        // Single event on source 2
        wr_reg(2'd2, 32'h0001_000F);
        raise(2, 16'h1234);
        idle(2);
        check("tp_irq_high", 32'(irq), 32'd1);
        rd_reg(2'd1);
        check("tp_pop_event", readdata, 32'hA000_1234);
        idle(1);
        check("tp_irq_low", 32'(irq), 32'd0);

        // All four held from reset: order 0,1,2,3
        repeat (2) step(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
        wr_reg(2'd2, 32'h0000_000F);
        ack_seen.delete();
        for (int i = 0; i < N; i++) raise(i, DW'(16'hA000 + i));
        idle(10);
        check("rr_count", 32'(ack_seen.size()), 32'd4);
        for (int i = 0; i < 4 && i < ack_seen.size(); i++)
            check("rr_order", ack_seen[i], 32'd1 << i);
        repeat (4) rd_reg(2'd1);

        // Fill to full with source 1 still requesting
        regen_always[1] = 1'b1;
        idle(20);
        rd_reg(2'd0);
        check("tp_full_status", readdata, 32'h0000_0802);
        check("tp_full_noack", 32'(ack), 32'd0);
        rd_reg(2'd1);
        idle(2);
        rd_reg(2'd0);
        check("tp_full_refill", readdata, 32'h0000_0802);
        regen_always[1] = 1'b0;
        repeat (12) rd_reg(2'd1);

        // Masking and EVCOUNT
        wr_reg(2'd3, 32'd0);
        wr_reg(2'd2, 32'h0001_0001);
        raise(3, 16'hBEEF);
        idle(6);
        wr_reg(2'd2, 32'h0001_0008);
        idle(2);
        rd_reg(2'd3);
        check("tp_evcount", readdata, 32'd1);
        wr_reg(2'd3, 32'hFFFF_FFFF);
        rd_reg(2'd3);
        check("tp_evcount_clr", readdata, 32'd0);
        repeat (2) rd_reg(2'd1);

        // Randomised traffic
        wr_reg(2'd2, 32'h0001_000F);
        regen_pct = 30;
        for (int it = 0; it < 800; it++) begin
            int r;
            r = $urandom_range(99);
            if (r < 35)      rd_reg(2'($urandom_range(3)));
            else if (r < 38) wr_reg(2'd2, {15'd0, 1'($urandom_range(1)), 12'd0, 4'($urandom_range(15))});
            else if (r < 40) wr_reg(2'd3, $urandom);
            else if (r < 42) wr_reg(2'($urandom_range(1)), $urandom);
            else             idle(1);
        end

        // Reset with queued events and pending requests
        wr_reg(2'd2, 32'h0001_000F);
        regen_pct = 100;
        idle(8);
        regen_pct = 0;
        repeat (2) step(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
        rd_reg(2'd0);
        check("tp_status_after_reset", readdata, 32'h0000_0001);
        wr_reg(2'd2, 32'h0000_000F);
        idle(8);
        repeat (10) rd_reg(2'd1);
        idle(4);

        check("ack_left", 32'(ack_exp.size()), 32'd0);
        check("rd_left", 32'(rd_exp.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pk_event_arbiter.md
# pk_event_arbiter

Collects peak-detect events from up to eight detector sources and serialises them into one queue that the Nios reads over a 4-word Avalon-MM slave. Each source raises a request with a data word. A round-robin arbiter grants one source per cycle into an event FIFO. The processor reads status, pops events and takes an interrupt while the queue is non-empty. Sits between the per-core peak-detect outputs and the Nios system interconnect, alongside the existing PIO slaves.

## Interface
Parameters:
- N_SRC, 4, number of detector sources (1..8)
- DW, 16, event data width (1..24)
- DEPTH, 8, FIFO depth in entries (power of two, 2..64)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  N_SRC  per-source event request, level, held until acked
- req_data  in  N_SRC*DW  per-source payload, slice i = source i, stable while req[i] high
- ack  out  N_SRC  one-cycle grant pulse per source
- address  in  2  Avalon word address
- read  in  1  Avalon read strobe
- write  in  1  Avalon write strobe
- writedata  in  32  Avalon write data
- readdata  out  32  registered read data
- irq  out  1  level interrupt to Nios

## Operation
- Register map:
  - 0 STATUS (RO): [15:8] count, [1] full, [0] empty.
  - 1 POP (RO, side effect): [31] valid, [30:28] source id, [DW-1:0] data, other bits 0.
  - 2 CTRL (RW): [N_SRC-1:0] source enable mask, [16] irq_en.
  - 3 EVCOUNT (RW): 32-bit total granted events, wraps at 2^32-1→0; any write clears it.
- Arbitration:
  - eligible[i] = req[i] & mask[i] & ~ack[i].
  - Round robin: search starts at last_grant+1 and wraps modulo N_SRC. last_grant resets to N_SRC-1, so source 0 has priority first.
  - A grant occurs only when the FIFO can accept: count<DEPTH, or a pop happens in the same cycle.
- On grant of source i in cycle t:
  - FIFO is written with {i, req_data[i]} at the end of t.
  - ack[i]=1 during t+1.
  - last_grant=i.
  - EVCOUNT increments.
- Requester rule: req[i] must be low from cycle t+2, unless a new event is pending. The ~ack mask prevents a double grant in t+1.
- Backpressure, no drops: when full, requests stay pending and no ack is issued.
- Disabled sources are never granted. Their req stays pending and is served once the source is re-enabled.
- POP read when empty: returns 0 (valid=0), no state change. Reads of other addresses have no side effect.
- Empty FIFO with a push and a POP in the same cycle: the pop sees empty (no bypass). The push completes.
- Full FIFO with a push and a POP in the same cycle: both occur, count unchanged.
- EVCOUNT write in the same cycle as a grant: clear wins, result 0.
- irq = irq_en & ~empty, registered (one cycle after the state change).

## Timing
- Reset values:
  - readdata=0, ack=0, irq=0
  - FIFO empty, count=0
  - mask=0, irq_en=0
  - EVCOUNT=0, last_grant=N_SRC-1
- Reset mid-operation flushes the FIFO. Pending reqs are re-arbitrated after release.
- Read latency: 1 cycle. readdata is valid in the cycle after read=1 and holds until the next read.
- Request-to-ack latency: 1 cycle minimum when uncontested and not full.
- Request-to-visible-in-STATUS latency: 2 cycles (push at edge, then registered read).
- Throughput: one grant per cycle and one pop per read.

## Structure
- Package pk_arb_pkg holds:
  - register address constants (ADDR_STATUS, ADDR_POP, ADDR_CTRL, ADDR_EVCOUNT)
  - bit positions (POP_VALID_BIT, POP_SRC_LSB, CTRL_IRQEN_BIT)
  - the event struct {src[2:0], data}
- Sub-module pk_event_fifo: synchronous FIFO with width 3+DW, parameter DEPTH, push/pop/full/empty/count.
- Top level holds the arbiter, register file and Avalon decode.

## Test plan
- Reset, then read STATUS → 0x00000001. Read POP → 0x00000000. irq=0.
- mask=0xF, irq_en=1; raise req[2] with data 0x1234 → ack[2] one cycle later. POP returns 0xA0001234. irq rises then falls after the pop.
- req[0..3] all held continuously → grants in order 0,1,2,3. Each source is acked exactly once per request, with no double ack.
- Fill FIFO to 8 with req[1] still high → STATUS=0x0802 and no ack. One POP → ack[1] in the same or next cycle, count stays 8.
- mask=0x1 with req[3] high → never acked. Write mask=0x8 → ack[3] within 2 cycles. EVCOUNT reads the number of grants; a write clears it to 0.
- Assert reset with 5 queued events and pending reqs → all outputs at reset values. After release and re-enabling the mask, the pending reqs are granted afresh.
